// File: rtl/apb_exe_pkg.sv
// rtl/apb_exe_pkg.sv - register map, sequencer states and bit positions for apb_exe_frontend
package apb_exe_pkg;

  localparam int unsigned ADDR_ARG_A  = 32'h00;
  localparam int unsigned ADDR_ARG_B  = 32'h04;
  localparam int unsigned ADDR_CTRL   = 32'h08;
  localparam int unsigned ADDR_STATUS = 32'h0C;
  localparam int unsigned ADDR_RESULT = 32'h10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } seq_state_t;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERROR = 2;

  localparam int CTRL_START = 31;

endpackage

// File: rtl/apb_exe_seq.sv
// rtl/apb_exe_seq.sv - issue/capture sequencer holding busy, done, error and RESULT
module apb_exe_seq
  import apb_exe_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         clr_done,
  input  logic [M-1:0] y,
  input  logic         y_error,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [M-1:0] result
);

  seq_state_t state;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      done   <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            done  <= 1'b0;
            error <= 1'b0;
            state <= ST_ISSUE;
          end else if (clr_done) begin
            done <= 1'b0;
          end
        end
        // operands have been stable for a full cycle; the unit output is settled
        ST_ISSUE: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          result <= y;
          error  <= y_error;
          done   <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apb_exe_frontend.sv
// rtl/apb_exe_frontend.sv - APB3 register front-end feeding a combinational execution unit
module apb_exe_frontend
  import apb_exe_pkg::*;
#(
  parameter int M   = 8,
  parameter int OPW = 2,
  parameter int AW  = 5
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [AW-1:0]  PADDR,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic           PSLVERR,
  output logic [M-1:0]   o_argA,
  output logic [M-1:0]   o_argB,
  output logic [OPW-1:0] o_op,
  input  logic [M-1:0]   i_y,
  input  logic           i_error
);

  logic [M-1:0]   arg_a;
  logic [M-1:0]   arg_b;
  logic [OPW-1:0] op;
  logic           busy;
  logic           done;
  logic           error;
  logic [M-1:0]   result;

  logic access;
  logic sel_a, sel_b, sel_ctrl, sel_stat, sel_res, mapped;
  logic err_cond;
  logic wr_fire;
  logic rd_res_fire;
  logic start;
  logic unused_pwdata;

  assign access   = PSEL & PENABLE;
  assign sel_a    = (PADDR == AW'(ADDR_ARG_A));
  assign sel_b    = (PADDR == AW'(ADDR_ARG_B));
  assign sel_ctrl = (PADDR == AW'(ADDR_CTRL));
  assign sel_stat = (PADDR == AW'(ADDR_STATUS));
  assign sel_res  = (PADDR == AW'(ADDR_RESULT));
  // exact matches also reject misaligned and out-of-range addresses
  assign mapped   = sel_a | sel_b | sel_ctrl | sel_stat | sel_res;

  assign err_cond = !mapped
                  | (PWRITE & (sel_stat | sel_res))
                  | (PWRITE & busy & (sel_a | sel_b | sel_ctrl));

  assign PSLVERR = access & err_cond;
  assign PREADY  = !(access & !PWRITE & sel_res & busy);

  assign wr_fire     = access & PWRITE & !err_cond;
  assign rd_res_fire = access & !PWRITE & sel_res & PREADY;
  assign start       = wr_fire & sel_ctrl & PWDATA[CTRL_START];

  assign unused_pwdata = ^PWDATA;

  always_comb begin
    PRDATA = '0;
    if (access && !err_cond) begin
      if (sel_a)    PRDATA[M-1:0]   = arg_a;
      if (sel_b)    PRDATA[M-1:0]   = arg_b;
      if (sel_ctrl) PRDATA[OPW-1:0] = op;
      if (sel_stat) begin
        PRDATA[STAT_BUSY]  = busy;
        PRDATA[STAT_DONE]  = done;
        PRDATA[STAT_ERROR] = error;
      end
      if (sel_res)  PRDATA[M-1:0]   = result;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      arg_a <= '0;
      arg_b <= '0;
      op    <= '0;
    end else if (wr_fire) begin
      if (sel_a)    arg_a <= PWDATA[M-1:0];
      if (sel_b)    arg_b <= PWDATA[M-1:0];
      if (sel_ctrl) op    <= PWDATA[OPW-1:0];
    end
  end

  assign o_argA = arg_a;
  assign o_argB = arg_b;
  assign o_op   = op;

  apb_exe_seq #(
    .M(M)
  ) u_seq (
    .clk      (PCLK),
    .resetn   (PRESETn),
    .start    (start),
    .clr_done (rd_res_fire),
    .y        (i_y),
    .y_error  (i_error),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .result   (result)
  );

endmodule
